mul_div_unit: RTL



---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_step.sv | 40 ++++
 rtl/mul_div_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and sizing helpers for the multiply/divide unit
//
// Contents:
//   mdu_op_e    : operation codes as driven on mul_div_unit.op
//   mdu_state_e : control FSM states
//   cnt_width() : iteration counter width for a given operand width
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } mdu_state_e;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int MDU_CNT_W = cnt_width(MDU_WIDTH);

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational shift-add / restoring-divide iteration
//
// Ports:
//   acc_in  [2W-1:0] : accumulator before the step ({hi_part, lo_part})
//   opnd    [W-1:0]  : multiplicand magnitude (mul) or divisor magnitude (div)
//   is_div           : 1 selects a restoring-divide step, 0 a shift-add step
//   acc_out [2W-1:0] : accumulator after the step
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_out
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: conditional add into the upper half, carry kept so the
    // following right shift brings it down into the product.
    sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, opnd} : '0);
    // Divide: the remainder after the left shift is WIDTH+1 bits wide
    // (its top bit is the one shifted out of acc_in), so subtract from that.
    // diff[WIDTH] acts as the borrow: the partial remainder is always below
    // twice the divisor, so a WIDTH+1-bit result is enough to tell the sign.
    diff = acc_in[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};

    acc_out = {sum, acc_in[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        acc_out = {diff[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_out = {acc_in[2*WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit producing HI/LO
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start, op[1:0]     : issue request and operation (sampled only while idle)
//   Adat, Bdat [W-1:0] : multiplicand/dividend, multiplier/divisor
//   busy               : operation in progress, starts ignored
//   done               : one-cycle pulse when hi/lo/div_by_zero are updated
//   hi, lo [W-1:0]     : product halves, or remainder/quotient
//   div_by_zero        : last completed operation was a divide by zero
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Adat,
  input  logic [WIDTH-1:0] Bdat,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  mdu_state_e state, state_next;
  mdu_op_e    op_in;

  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div_q;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;

  logic               in_signed;
  logic               in_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_in     = mdu_op_e'(op);
  assign in_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
  assign in_div    = (op_in == OP_DIVU) || (op_in == OP_DIV);
  assign a_mag     = (in_signed && Adat[WIDTH-1]) ? -Adat : Adat;
  assign b_mag     = (in_signed && Bdat[WIDTH-1]) ? -Bdat : Bdat;

  // Sign correction applied at FIX. neg_q covers both the product sign
  // (MULT) and the quotient sign (DIV); neg_r is the dividend sign.
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != S_IDLE);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc_in  (acc),
    .opnd    (opnd),
    .is_div  (is_div_q),
    .acc_out (acc_step)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  if (cnt == '0) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      a_raw       <= '0;
      is_div_q    <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      b_zero      <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            // Multiply keeps the multiplier in the low half and adds the
            // multiplicand; divide shifts the dividend up out of the low half.
            acc      <= {{WIDTH{1'b0}}, (in_div ? a_mag : b_mag)};
            opnd     <= in_div ? b_mag : a_mag;
            a_raw    <= Adat;
            is_div_q <= in_div;
            neg_q    <= in_signed && (Adat[WIDTH-1] ^ Bdat[WIDTH-1]);
            neg_r    <= (op_in == OP_DIV) && Adat[WIDTH-1];
            b_zero   <= (Bdat == '0);
            cnt      <= CW'(WIDTH - 1);
          end
        end
        S_CALC: begin
          acc <= acc_step;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_FIX: begin
          done <= 1'b1;
          if (is_div_q && b_zero) begin
            hi          <= a_raw;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else if (is_div_q) begin
            hi          <= rem_fix;
            lo          <= quo_fix;
            div_by_zero <= 1'b0;
          end else begin
            hi          <= prod_fix[2*WIDTH-1:WIDTH];
            lo          <= prod_fix[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
